fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 150 +++++++++++++++
 tb/tb_fetch_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: drives the program counter and instruction-memory request.
// It sequences boot, normal fetch, memory-latency waits and redirect draining,
// and arbitrates trap/branch redirects against stalls and in-flight requests.
module fetch_controller #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter int unsigned BOOT_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc,
    input  logic        stall,
    output logic        memReq,
    input  logic        memReady,
    input  logic        branchTaken,
    input  logic [63:0] branchTarget,
    input  logic        trapReq,
    input  logic [63:0] trapVector,
    output logic [63:0] nextPc,
    output logic        pcStall,
    output logic        fetchValid,
    output logic        flush
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] BOOT_INIT = 8'(BOOT_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  boot_cnt_q, boot_cnt_d;
    logic [63:0] pending_pc_q, pending_pc_d;

    logic        redirect;
    logic [63:0] redirect_pc;
    logic [63:0] pc_plus4;

    // Trap wins over branch; redirect targets are always word aligned.
    assign redirect    = trapReq | branchTaken;
    assign redirect_pc = (trapReq ? trapVector : branchTarget) & ~64'h3;
    // Natural 64-bit add: the carry out is dropped, so the top word wraps to 0.
    assign pc_plus4    = pc + 64'd4;

    // State register with synchronous reset; reset abandons any in-flight fetch.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge values of its neighbours, independent of statement order.
        if (rst) begin
            state_q      <= ST_BOOT;
            boot_cnt_q   <= BOOT_INIT;
            pending_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            boot_cnt_q   <= boot_cnt_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    // Next-state and combinational outputs from current state and inputs.
    always_comb begin
        // NOTE: every output and _d signal gets a default before the case so
        // no path leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        pending_pc_d = pending_pc_q;
        nextPc       = pc;
        pcStall      = 1'b0;
        memReq       = 1'b0;
        fetchValid   = 1'b0;
        flush        = 1'b0;

        if (rst) begin
            nextPc = RESET_VECTOR;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    // Redirects and memReady are ignored until boot finishes.
                    nextPc     = RESET_VECTOR;
                    boot_cnt_d = boot_cnt_q - 8'd1;
                    if (boot_cnt_q <= 8'd1) begin
                        state_d = ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    memReq = 1'b1;
                    if (redirect) begin
                        nextPc = redirect_pc;
                        flush  = 1'b1;
                    end else if (memReady && !stall) begin
                        nextPc     = pc_plus4;
                        fetchValid = 1'b1;
                    end else if (memReady) begin
                        // Decode is stalled: hold pc and re-request next cycle.
                        pcStall = 1'b1;
                    end else begin
                        pcStall = 1'b1;
                        state_d = ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    memReq  = 1'b1;
                    pcStall = 1'b1;
                    if (redirect && memReady) begin
                        nextPc  = redirect_pc;
                        pcStall = 1'b0;
                        flush   = 1'b1;
                        state_d = ST_FETCH;
                    end else if (redirect) begin
                        // Request still in flight: remember where to go once
                        // the stale instruction has returned.
                        pending_pc_d = redirect_pc;
                        state_d      = ST_DRAIN;
                    end else if (memReady) begin
                        state_d = ST_FETCH;
                        if (!stall) begin
                            nextPc     = pc_plus4;
                            pcStall    = 1'b0;
                            fetchValid = 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    memReq  = 1'b1;
                    pcStall = 1'b1;
                    if (redirect) begin
                        pending_pc_d = redirect_pc;
                    end
                    if (memReady) begin
                        // Returned instruction belongs to the squashed path.
                        nextPc  = redirect ? redirect_pc : pending_pc_q;
                        pcStall = 1'b0;
                        flush   = 1'b1;
                        state_d = ST_FETCH;
                    end
                end

                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed-vector bench for fetch_controller.
// Each vector is one cycle of inputs plus the outputs expected in that cycle.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pc = '0;
    logic        stall = 1'b0;
    logic        memReq;
    logic        memReady = 1'b0;
    logic        branchTaken = 1'b0;
    logic [63:0] branchTarget = '0;
    logic        trapReq = 1'b0;
    logic [63:0] trapVector = '0;
    logic [63:0] nextPc;
    logic        pcStall;
    logic        fetchValid;
    logic        flush;

    int errors = 0;
    int checks = 0;

    // Expected flag sets {memReq, pcStall, fetchValid, flush}.
    localparam logic [3:0] F_IDLE = 4'b0000;
    localparam logic [3:0] F_ACC  = 4'b1010;
    localparam logic [3:0] F_HOLD = 4'b1100;
    localparam logic [3:0] F_RDR  = 4'b1001;

    typedef struct {
        logic        r;
        logic [63:0] p;
        logic        st;
        logic        mr;
        logic        bt;
        logic [63:0] bt_t;
        logic        tr;
        logic [63:0] tv_t;
        logic [63:0] e_pc;
        logic [3:0]  e_f;
    } vec_t;

    fetch_controller dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .stall        (stall),
        .memReq       (memReq),
        .memReady     (memReady),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .trapReq      (trapReq),
        .trapVector   (trapVector),
        .nextPc       (nextPc),
        .pcStall      (pcStall),
        .fetchValid   (fetchValid),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(logic r, logic [63:0] p, logic st, logic mr,
                               logic bt, logic [63:0] bt_t, logic tr, logic [63:0] tv_t,
                               logic [63:0] e_pc, logic [3:0] e_f);
        vec_t x;
        x.r = r; x.p = p; x.st = st; x.mr = mr; x.bt = bt; x.bt_t = bt_t;
        x.tr = tr; x.tv_t = tv_t; x.e_pc = e_pc; x.e_f = e_f;
        return x;
    endfunction

    // Apply one cycle of inputs mid-period; outputs settle before the next posedge.
    task automatic drive(input vec_t x);
        @(negedge clk);
        rst = x.r; pc = x.p; stall = x.st; memReady = x.mr;
        branchTaken = x.bt; branchTarget = x.bt_t; trapReq = x.tr; trapVector = x.tv_t;
        #1;
    endtask

    // nextPc is only meaningful when pcStall is expected low.
    task automatic test_reset;
        vec_t q[$];
        logic [67:0] obs, exp;
        q.push_back(v(1, 64'h0,  0, 1, 0, 64'h0,   0, 64'h0, 64'h0,  F_IDLE));
        q.push_back(v(0, 64'h0,  0, 1, 0, 64'h0,   0, 64'h0, 64'h0,  F_IDLE));
        q.push_back(v(0, 64'h0,  0, 1, 1, 64'h500, 0, 64'h0, 64'h0,  F_IDLE));
        q.push_back(v(0, 64'h0,  0, 1, 0, 64'h0,   1, 64'h9, 64'h0,  F_IDLE));
        q.push_back(v(0, 64'h0,  0, 1, 0, 64'h0,   0, 64'h0, 64'h0,  F_IDLE));
        q.push_back(v(0, 64'h0,  0, 1, 0, 64'h0,   0, 64'h0, 64'h4,  F_ACC));
        q.push_back(v(0, 64'h4,  0, 1, 0, 64'h0,   0, 64'h0, 64'h8,  F_ACC));
        q.push_back(v(0, 64'h8,  0, 1, 0, 64'h0,   0, 64'h0, 64'hC,  F_ACC));
        q.push_back(v(0, 64'hC,  0, 1, 0, 64'h0,   0, 64'h0, 64'h10, F_ACC));
        foreach (q[i]) begin
            drive(q[i]);
            obs = {(q[i].e_f[2] ? 64'h0 : nextPc), memReq, pcStall, fetchValid, flush};
            exp = {(q[i].e_f[2] ? 64'h0 : q[i].e_pc), q[i].e_f};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_boot[%0d] observed=%h expected=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_latency;
        vec_t q[$];
        logic [67:0] obs, exp;
        q.push_back(v(0, 64'h10, 0, 0, 0, 64'h0, 0, 64'h0, 64'h0,  F_HOLD));
        q.push_back(v(0, 64'h10, 0, 0, 0, 64'h0, 0, 64'h0, 64'h0,  F_HOLD));
        q.push_back(v(0, 64'h10, 0, 0, 0, 64'h0, 0, 64'h0, 64'h0,  F_HOLD));
        q.push_back(v(0, 64'h10, 0, 1, 0, 64'h0, 0, 64'h0, 64'h14, F_ACC));
        q.push_back(v(0, 64'h14, 1, 1, 0, 64'h0, 0, 64'h0, 64'h0,  F_HOLD));
        q.push_back(v(0, 64'h14, 0, 0, 0, 64'h0, 0, 64'h0, 64'h0,  F_HOLD));
        q.push_back(v(0, 64'h14, 1, 1, 0, 64'h0, 0, 64'h0, 64'h0,  F_HOLD));
        q.push_back(v(0, 64'h14, 0, 1, 0, 64'h0, 0, 64'h0, 64'h18, F_ACC));
        foreach (q[i]) begin
            drive(q[i]);
            obs = {(q[i].e_f[2] ? 64'h0 : nextPc), memReq, pcStall, fetchValid, flush};
            exp = {(q[i].e_f[2] ? 64'h0 : q[i].e_pc), q[i].e_f};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL latency[%0d] observed=%h expected=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_drain;
        vec_t q[$];
        logic [67:0] obs, exp;
        // Branch while waiting, drained two cycles later.
        q.push_back(v(0, 64'h40,  0, 0, 0, 64'h0,   0, 64'h0,   64'h0,   F_HOLD));
        q.push_back(v(0, 64'h40,  0, 0, 1, 64'h203, 0, 64'h0,   64'h0,   F_HOLD));
        q.push_back(v(0, 64'h40,  0, 0, 0, 64'h0,   0, 64'h0,   64'h0,   F_HOLD));
        q.push_back(v(0, 64'h40,  0, 1, 0, 64'h0,   0, 64'h0,   64'h200, F_RDR));
        q.push_back(v(0, 64'h200, 0, 1, 0, 64'h0,   0, 64'h0,   64'h204, F_ACC));
        // Trap beats branch into pendingPc, later overwritten by a branch.
        q.push_back(v(0, 64'h204, 0, 0, 0, 64'h0,   0, 64'h0,   64'h0,   F_HOLD));
        q.push_back(v(0, 64'h204, 0, 0, 1, 64'h300, 1, 64'h900, 64'h0,   F_HOLD));
        q.push_back(v(0, 64'h204, 0, 0, 1, 64'h311, 0, 64'h0,   64'h0,   F_HOLD));
        q.push_back(v(0, 64'h204, 1, 0, 0, 64'h0,   0, 64'h0,   64'h0,   F_HOLD));
        q.push_back(v(0, 64'h204, 1, 1, 0, 64'h0,   0, 64'h0,   64'h310, F_RDR));
        // Redirect in WAIT together with memReady, under stall.
        q.push_back(v(0, 64'h310, 0, 0, 0, 64'h0,   0, 64'h0,   64'h0,   F_HOLD));
        q.push_back(v(0, 64'h310, 1, 1, 1, 64'h446, 0, 64'h0,   64'h444, F_RDR));
        q.push_back(v(0, 64'h444, 0, 1, 0, 64'h0,   0, 64'h0,   64'h448, F_ACC));
        // Redirect arriving with memReady in DRAIN replaces pendingPc.
        q.push_back(v(0, 64'h448, 0, 0, 0, 64'h0,   0, 64'h0,   64'h0,   F_HOLD));
        q.push_back(v(0, 64'h448, 0, 0, 1, 64'h600, 0, 64'h0,   64'h0,   F_HOLD));
        q.push_back(v(0, 64'h448, 0, 1, 0, 64'h0,   1, 64'h707, 64'h704, F_RDR));
        foreach (q[i]) begin
            drive(q[i]);
            obs = {(q[i].e_f[2] ? 64'h0 : nextPc), memReq, pcStall, fetchValid, flush};
            exp = {(q[i].e_f[2] ? 64'h0 : q[i].e_pc), q[i].e_f};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL drain[%0d] observed=%h expected=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_simultaneous;
        vec_t q[$];
        logic [67:0] obs, exp;
        q.push_back(v(0, 64'h704, 1, 1, 1, 64'h100, 1, 64'h800, 64'h800, F_RDR));
        q.push_back(v(0, 64'h800, 1, 0, 1, 64'h102, 0, 64'h0,   64'h100, F_RDR));
        q.push_back(v(0, 64'h100, 0, 1, 0, 64'h0,   0, 64'h0,   64'h104, F_ACC));
        foreach (q[i]) begin
            drive(q[i]);
            obs = {(q[i].e_f[2] ? 64'h0 : nextPc), memReq, pcStall, fetchValid, flush};
            exp = {(q[i].e_f[2] ? 64'h0 : q[i].e_pc), q[i].e_f};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL simultaneous[%0d] observed=%h expected=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_wrap;
        vec_t q[$];
        logic [67:0] obs, exp;
        q.push_back(v(0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0, 64'h0, 0, 64'h0, 64'h0, F_ACC));
        q.push_back(v(0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1, 0, 64'h0, 0, 64'h0,
                      64'hFFFF_FFFF_FFFF_FFFC, F_ACC));
        foreach (q[i]) begin
            drive(q[i]);
            obs = {(q[i].e_f[2] ? 64'h0 : nextPc), memReq, pcStall, fetchValid, flush};
            exp = {(q[i].e_f[2] ? 64'h0 : q[i].e_pc), q[i].e_f};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL wrap[%0d] observed=%h expected=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_drain;
        vec_t q[$];
        logic [67:0] obs, exp;
        q.push_back(v(0, 64'h20, 0, 0, 0, 64'h0,   0, 64'h0, 64'h0, F_HOLD));
        q.push_back(v(0, 64'h20, 0, 0, 1, 64'hA00, 0, 64'h0, 64'h0, F_HOLD));
        q.push_back(v(0, 64'h20, 0, 0, 0, 64'h0,   0, 64'h0, 64'h0, F_HOLD));
        q.push_back(v(1, 64'h20, 0, 1, 0, 64'h0,   0, 64'h0, 64'h0, F_IDLE));
        q.push_back(v(0, 64'h20, 0, 1, 0, 64'h0,   0, 64'h0, 64'h0, F_IDLE));
        q.push_back(v(0, 64'h0,  0, 1, 0, 64'h0,   0, 64'h0, 64'h0, F_IDLE));
        q.push_back(v(0, 64'h0,  0, 1, 0, 64'h0,   0, 64'h0, 64'h0, F_IDLE));
        q.push_back(v(0, 64'h0,  0, 1, 0, 64'h0,   0, 64'h0, 64'h0, F_IDLE));
        q.push_back(v(0, 64'h0,  0, 1, 0, 64'h0,   0, 64'h0, 64'h4, F_ACC));
        q.push_back(v(0, 64'h4,  0, 1, 0, 64'h0,   0, 64'h0, 64'h8, F_ACC));
        foreach (q[i]) begin
            drive(q[i]);
            obs = {(q[i].e_f[2] ? 64'h0 : nextPc), memReq, pcStall, fetchValid, flush};
            exp = {(q[i].e_f[2] ? 64'h0 : q[i].e_pc), q[i].e_f};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_drain[%0d] observed=%h expected=%h", i, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_reset_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
